clk_rst_seq: RTL and testbench

Reset sequencer between the iCE40 PLL wrapper and the RV32I core. Watches the PLL lock flag and the board reset button, and requires lock to be stable before releasing the core reset. After that it applies a fixed hold-off, then deasserts a clean, registered, active-low reset into the core clock domain. An optional watchdog can force the core back through the sequence.

---
 rtl/clk_rst_pkg.sv | 20 ++
 rtl/bit_sync.sv | 31 +++
 rtl/clk_rst_seq.sv | 188 ++++++++++++++++++
 tb/tb_clk_rst_seq.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// ---------------------------------------------------------------------------
// clk_rst_pkg
// Shared definitions for the PLL-lock / core reset sequencer.
//   ST_WAIT_LOCK, ST_HOLD, ST_RUN : FSM state encoding (also driven on the
//                                   debug 'state' output, so the codes are fixed)
//   ST_UNUSED                     : illegal code, recovers to ST_WAIT_LOCK
//   max_int()                     : elaboration helper for counter sizing
// ---------------------------------------------------------------------------
package clk_rst_pkg;

  localparam logic [1:0] ST_UNUSED    = 2'b00;
  localparam logic [1:0] ST_WAIT_LOCK = 2'b01;
  localparam logic [1:0] ST_HOLD      = 2'b10;
  localparam logic [1:0] ST_RUN       = 2'b11;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// N-stage flip-flop synchronizer for a single asynchronous level.
//   STAGES : number of flops in the chain (>= 2)
//   clk    : destination clock
//   resetn : asynchronous active-low reset, all stages clear to 0
//   d      : asynchronous input
//   q      : synchronized output (last stage)
// ---------------------------------------------------------------------------
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/clk_rst_seq.sv
// ---------------------------------------------------------------------------
// clk_rst_seq
// Reset sequencer between the PLL wrapper and the core. Waits for PLL lock
// and the board button to be stable for LOCK_CYCLES, applies a HOLD_CYCLES
// hold-off, then releases a registered active-low core reset.
//
// Optional feature macro: WATCHDOG_EN
//   defined   : watchdog of WDT_CYCLES in RUN, kicked by wdt_kick; expiry
//               forces the sequence to restart and sets sticky wdt_fired
//   undefined : no watchdog, wdt_kick ignored, wdt_fired tied to 0
//
// Parameters: SYNC_STAGES (>=2), LOCK_CYCLES (>=1), HOLD_CYCLES (>=1),
//             WDT_CYCLES (>=2)
// Ports:
//   clk        in   PLL output clock, only clock
//   resetn     in   asynchronous active-low reset of this block
//   pll_lock   in   PLL lock flag, asynchronous
//   ext_resetn in   board reset button, active-low, asynchronous
//   wdt_kick   in   single-cycle synchronous kick strobe from the core
//   cpu_resetn out  registered active-low core reset
//   ready      out  high while in RUN (same as cpu_resetn)
//   state      out  current FSM state for debug LEDs
//   wdt_fired  out  sticky watchdog-expired flag
//
// state        | meaning
// -------------+----------------------------------------------------------
// WAIT_LOCK 01 | core in reset, counting LOCK_CYCLES of stable lock/button
// HOLD      10 | core in reset, counting HOLD_CYCLES hold-off
// RUN       11 | core reset released; watchdog active when built
// (00)         | unused, recovers to WAIT_LOCK
// ---------------------------------------------------------------------------
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 4096,
  parameter int WDT_CYCLES  = 16777216
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       ext_resetn,
  input  logic       wdt_kick,
  output logic       cpu_resetn,
  output logic       ready,
  output logic [1:0] state,
  output logic       wdt_fired
);

  // A single counter serves both the lock qualification and the hold-off.
  // Width is floored at 1 so LOCK_CYCLES = HOLD_CYCLES = 1 still elaborates.
  localparam int CW = max_int(1, $clog2(max_int(LOCK_CYCLES, HOLD_CYCLES)));
  localparam logic [CW-1:0] LOCK_TC = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("clk_rst_seq: SYNC_STAGES must be >= 2");
    end
    if (LOCK_CYCLES < 1) begin : g_bad_lock
      $error("clk_rst_seq: LOCK_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("clk_rst_seq: HOLD_CYCLES must be >= 1");
    end
    if (WDT_CYCLES < 2) begin : g_bad_wdt
      $error("clk_rst_seq: WDT_CYCLES must be >= 2");
    end
  endgenerate

  logic          lock_s;
  logic          btn_s;
  logic          ok;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [1:0]    state_nxt;
  logic          wdt_expire;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_lock),
    .q      (lock_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_btn (
    .clk    (clk),
    .resetn (resetn),
    .d      (ext_resetn),
    .q      (btn_s)
  );

  assign ok = lock_s & btn_s;

  // Next-state and counter decode. Loss of ok is tested first in every
  // state so it always beats a terminal count or a watchdog expiry.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT_LOCK: begin
        if (!ok) begin
          cnt_nxt = '0;
        end else if (cnt == LOCK_TC) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_HOLD: begin
        if (!ok) begin
          state_nxt = ST_WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_TC) begin
          // Counter parked at 0 in RUN so any later restart counts a full
          // LOCK_CYCLES window.
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_RUN: begin
        cnt_nxt = '0;
        if (!ok || wdt_expire) begin
          state_nxt = ST_WAIT_LOCK;
        end
      end
      default: begin
        state_nxt = ST_WAIT_LOCK;
        cnt_nxt   = '0;
      end
    endcase
  end

  // cpu_resetn/ready come from the next-state decode so they switch on the
  // same edge as 'state' and leave the block straight from a flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= ST_WAIT_LOCK;
      cnt        <= '0;
      cpu_resetn <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      cpu_resetn <= (state_nxt == ST_RUN);
      ready      <= (state_nxt == ST_RUN);
    end
  end

`ifdef WATCHDOG_EN
  localparam int WW = $clog2(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_TC = WW'(WDT_CYCLES - 1);

  logic [WW-1:0] wdt_cnt;

  // A kick in the terminal cycle still rescues the core.
  assign wdt_expire = (state == ST_RUN) && !wdt_kick && (wdt_cnt == WDT_TC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdt_cnt   <= '0;
      wdt_fired <= 1'b0;
    end else begin
      if ((state == ST_RUN) && (state_nxt == ST_RUN)) begin
        wdt_cnt <= wdt_kick ? '0 : wdt_cnt + 1'b1;
      end else begin
        wdt_cnt <= '0;
      end
      // Only flag an expiry that actually caused the restart; a lock loss
      // in the same cycle takes precedence.
      if (wdt_expire && ok) begin
        wdt_fired <= 1'b1;
      end
    end
  end
`else
  logic unused_wdt_kick;

  assign unused_wdt_kick = wdt_kick;
  assign wdt_expire      = 1'b0;
  assign wdt_fired       = 1'b0;
`endif

endmodule

// File: tb/tb_clk_rst_seq.sv
`timescale 1ns/1ps
module tb_clk_rst_seq;

  localparam int SYNC  = 2;
  localparam int LOCKC = 4;
  localparam int HOLDC = 8;
  localparam int WDTC  = 16;

  logic       clk        = 1'b0;
  logic       resetn     = 1'b0;
  logic       pll_lock   = 1'b0;
  logic       ext_resetn = 1'b0;
  logic       wdt_kick   = 1'b0;
  logic       cpu_resetn;
  logic       ready;
  logic [1:0] state;
  logic       wdt_fired;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  clk_rst_seq #(
    .SYNC_STAGES (SYNC),
    .LOCK_CYCLES (LOCKC),
    .HOLD_CYCLES (HOLDC),
    .WDT_CYCLES  (WDTC)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pll_lock   (pll_lock),
    .ext_resetn (ext_resetn),
    .wdt_kick   (wdt_kick),
    .cpu_resetn (cpu_resetn),
    .ready      (ready),
    .state      (state),
    .wdt_fired  (wdt_fired)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: time-stamp based. Each phase remembers the edge at
  // which its window started; a phase completes when the edge index is
  // exactly its length past that reference with ok held throughout.
  int m_phase;
  int m_edge;
  int m_ref;
  int m_wref;
  bit m_fired;
  bit m_hist[SYNC];

  task automatic model_reset();
    m_phase = 1;
    m_edge  = 0;
    m_ref   = 0;
    m_wref  = 0;
    m_fired = 1'b0;
    for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
  endtask

  task automatic model_step();
    bit ok;
    ok = m_hist[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = pll_lock & ext_resetn;
    m_edge++;
    case (m_phase)
      1: begin
        if (!ok) m_ref = m_edge;
        else if (m_edge - m_ref == LOCKC) begin
          m_phase = 2;
          m_ref   = m_edge;
        end
      end
      2: begin
        if (!ok) begin
          m_phase = 1;
          m_ref   = m_edge;
        end else if (m_edge - m_ref == HOLDC) begin
          m_phase = 3;
          m_ref   = m_edge;
          m_wref  = m_edge;
        end
      end
      3: begin
        if (!ok) begin
          m_phase = 1;
          m_ref   = m_edge;
        end
`ifdef WATCHDOG_EN
        else if (wdt_kick) m_wref = m_edge;
        else if (m_edge - m_wref == WDTC) begin
          m_phase = 1;
          m_ref   = m_edge;
          m_fired = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    logic [1:0] exp_state;
    forever begin
      @(negedge clk);
      exp_state = m_phase[1:0];
      check("state", state, exp_state);
      check("cpu_resetn", cpu_resetn, m_phase == 3);
      check("ready", ready, m_phase == 3);
      check("wdt_fired", wdt_fired, m_fired);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expects ok to have just become stable at this negedge (first sampled
  // on the next edge) with the FSM in WAIT_LOCK and cnt = 0.
  task automatic expect_release(input string tag);
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      if (e == 5)  check({tag, "_wait_e5"}, state, 2'b01);
      if (e == 6)  check({tag, "_hold_e6"}, state, 2'b10);
      if (e == 13) check({tag, "_rst_e13"}, cpu_resetn, 1'b0);
      if (e == 14) begin
        check({tag, "_run_e14"}, state, 2'b11);
        check({tag, "_rel_e14"}, cpu_resetn, 1'b1);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end, got %0d vectors expected completion", vectors);
    $fatal(1, "timeout");
  end

  initial begin
    int seg_len;
    int kdiv;

    // Power-up with lock and button already high.
    pll_lock   = 1'b1;
    ext_resetn = 1'b1;
    cyc(3);
    check("reset_state", state, 2'b01);
    check("reset_cpu_resetn", cpu_resetn, 1'b0);
    check("reset_wdt_fired", wdt_fired, 1'b0);
    resetn = 1'b1;
    expect_release("powerup");

    // Lock drop in RUN: core reset asserts on the third edge.
    cyc(3);
    pll_lock = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      if (e == 2) check("drop_e2_still_run", cpu_resetn, 1'b1);
      if (e == 3) begin
        check("drop_e3_cpu_resetn", cpu_resetn, 1'b0);
        check("drop_e3_state", state, 2'b01);
      end
    end
    pll_lock = 1'b1;
    expect_release("relock");

    // Lock glitch: high 3, low 1, then high.
    pll_lock = 1'b0;
    cyc(6);
    pll_lock = 1'b1;
    cyc(3);
    pll_lock = 1'b0;
    cyc(1);
    pll_lock = 1'b1;
    expect_release("glitch");

    // Button pressed for one cycle during HOLD.
    pll_lock = 1'b0;
    cyc(4);
    pll_lock = 1'b1;
    cyc(8);
    check("btn_in_hold", state, 2'b10);
    ext_resetn = 1'b0;
    cyc(1);
    ext_resetn = 1'b1;
    expect_release("button");

`ifdef WATCHDOG_EN
    // Regular kicks keep the core running.
    repeat (5) begin
      wdt_kick = 1'b1;
      cyc(1);
      wdt_kick = 1'b0;
      cyc(9);
    end
    check("wdt_kicked_run", state, 2'b11);
    // Kick landing exactly in the terminal cycle wins.
    wdt_kick = 1'b1;
    cyc(1);
    wdt_kick = 1'b0;
    cyc(15);
    wdt_kick = 1'b1;
    cyc(1);
    wdt_kick = 1'b0;
    check("wdt_kick_at_tc", state, 2'b11);
    check("wdt_kick_at_tc_flag", wdt_fired, 1'b0);
    // Kicks stop: expiry 16 edges after the last kick.
    for (int e = 1; e <= 16; e++) begin
      @(negedge clk);
      if (e == 15) check("wdt_e15_run", state, 2'b11);
      if (e == 16) begin
        check("wdt_e16_state", state, 2'b01);
        check("wdt_e16_fired", wdt_fired, 1'b1);
      end
    end
    // Relock through the full 4+8 sequence, flag stays sticky.
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      if (e == 11) check("wdt_relock_e11", state, 2'b10);
      if (e == 12) check("wdt_relock_e12", state, 2'b11);
    end
    wdt_kick = 1'b1;
    cyc(1);
    wdt_kick = 1'b0;
    check("wdt_sticky", wdt_fired, 1'b1);
`else
    repeat (40) begin
      wdt_kick = ($urandom_range(0, 1) == 1);
      cyc(1);
    end
    wdt_kick = 1'b0;
    check("nowdt_run", state, 2'b11);
    check("nowdt_flag", wdt_fired, 1'b0);
`endif

    // Async reset mid-HOLD.
    pll_lock = 1'b0;
    cyc(5);
    pll_lock = 1'b1;
    cyc(9);
    check("arst_pre_hold", state, 2'b10);
    #2;
    resetn = 1'b0;
    #1;
    check("arst_state", state, 2'b01);
    check("arst_cpu_resetn", cpu_resetn, 1'b0);
    check("arst_ready", ready, 1'b0);
    check("arst_wdt_fired", wdt_fired, 1'b0);
    cyc(2);
    resetn = 1'b1;
    expect_release("after_arst");

    // Randomized segments checked by the model.
    for (int s = 0; s < 120; s++) begin
      seg_len    = $urandom_range(1, 40);
      kdiv       = ($urandom_range(0, 1) == 1) ? 3 : 40;
      pll_lock   = ($urandom_range(0, 9) < 8);
      ext_resetn = ($urandom_range(0, 9) < 9);
      for (int c = 0; c < seg_len; c++) begin
        wdt_kick = ($urandom_range(0, kdiv) == 0);
        if ($urandom_range(0, 299) == 0) begin
          #3;
          resetn = 1'b0;
          @(negedge clk);
          resetn = 1'b1;
        end else begin
          @(negedge clk);
        end
      end
    end
    wdt_kick = 1'b0;
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
